// File: rtl/axi4_stream_sched_pkg.sv
// Shared types and constants for the AXI4-Stream burst scheduler.
// Optional build macro used by the top level: AXI4_STREAM_BURST_SCHEDULER_ABORT_EN.
package axi4_stream_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } sched_state_e;

  localparam int TKEEP_WIDTH = 4;
  localparam int TDEST_WIDTH = 2;
  localparam int TID_WIDTH   = 8;
  localparam int GAP_CNT_W   = 4;

  // Round-robin successor of a requester index for a requester count of num_req.
  function automatic logic [TDEST_WIDTH-1:0] rr_next(input logic [TDEST_WIDTH-1:0] idx,
                                                     input int num_req);
    return (int'(idx) == num_req - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/axi4_stream_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping, returned as a one-hot grant plus its binary index.
module axi4_stream_rr_arbiter
  import axi4_stream_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [TDEST_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]     grant,
  output logic [TDEST_WIDTH-1:0] idx,
  output logic                   valid
);

  always_comb begin
    int k;
    // NOTE: every output gets a default before the loop; a path that leaves a
    // combinational output unassigned would infer a latch.
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = (int'(ptr) + off) % NUM_REQ;
      if (!valid && req[k]) begin
        valid    = 1'b1;
        grant[k] = 1'b1;
        idx      = TDEST_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/axi4_stream_burst_scheduler.sv
// Round-robin burst scheduler driving an AXI4-Stream generator: grant, pace beats, TLAST.
// Define AXI4_STREAM_BURST_SCHEDULER_ABORT_EN to add the ABORT input and sticky ABORTED flag.
module axi4_stream_burst_scheduler
  import axi4_stream_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int LEN_W    = 32,
  parameter int IDLE_GAP = 2
) (
  input  logic                     ACLK,
  input  logic                     RSTN,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*LEN_W-1:0] REQ_LEN,
  output logic [NUM_REQ-1:0]       ACK,
  output logic [NUM_REQ-1:0]       DONE,
  input  logic                     TREADY,
  output logic                     TVALID,
  output logic                     TLAST,
  output logic [TDEST_WIDTH-1:0]   TDEST,
  output logic [TID_WIDTH-1:0]     TID,
  output logic [TKEEP_WIDTH-1:0]   TKEEP,
  output logic                     BUSY
`ifdef AXI4_STREAM_BURST_SCHEDULER_ABORT_EN
  ,
  input  logic                     ABORT,
  output logic                     ABORTED
`endif
);

  sched_state_e           state_q, state_d;
  logic [TDEST_WIDTH-1:0] idx_q, idx_d;
  logic [TDEST_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic                   done_q, done_d;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [TDEST_WIDTH-1:0] pick_idx;
  logic                   pick_valid;
  logic [LEN_W-1:0]       pick_len;

  logic streaming;
  logic active;
  logic at_last;
  logic beat_xfer;
  logic force_last;

  axi4_stream_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (REQ),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // One-hot grant selects the winner's length field without a variable shift.
  always_comb begin
    pick_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_len = pick_len | REQ_LEN[i*LEN_W +: LEN_W];
    end
  end

  assign streaming = (state_q == STREAM);
  assign active    = (state_q == GRANT) || streaming;
  assign at_last   = (cnt_q == len_q) || force_last;
  assign beat_xfer = streaming && TREADY;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          len_d   = pick_len;
          state_d = GRANT;
        end
      end
      GRANT: begin
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (beat_xfer) begin
          if (at_last) begin
            done_d  = 1'b1;
            ptr_d   = rr_next(idx_q, NUM_REQ);
            gap_d   = '0;
            state_d = (IDLE_GAP == 0) ? IDLE : GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_CNT_W'(IDLE_GAP - 1)) state_d = IDLE;
        else                                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge ACLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

`ifdef AXI4_STREAM_BURST_SCHEDULER_ABORT_EN
  logic abort_seen_q;
  logic force_last_q;
  logic aborted_q;

  // The forced TLAST only moves on a handshake so TLAST stays stable while stalled.
  always_ff @(posedge ACLK or negedge RSTN) begin
    if (!RSTN) begin
      abort_seen_q <= 1'b0;
      force_last_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else if (state_q == GRANT) begin
      abort_seen_q <= 1'b0;
      force_last_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else if (streaming) begin
      abort_seen_q <= abort_seen_q | ABORT;
      if (beat_xfer) begin
        if (at_last) aborted_q    <= force_last_q;
        else         force_last_q <= abort_seen_q | ABORT;
      end
    end
  end

  assign force_last = force_last_q;
  assign ABORTED    = aborted_q;
`else
  assign force_last = 1'b0;
`endif

  always_comb begin
    ACK  = '0;
    DONE = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ACK[i]  = (state_q == GRANT) && (int'(idx_q) == i);
      DONE[i] = done_q && (int'(idx_q) == i);
    end
  end

  assign TVALID = streaming;
  assign TLAST  = streaming && at_last;
  assign TDEST  = active ? idx_q : '0;
  assign TID    = {{(TID_WIDTH - TDEST_WIDTH){1'b0}}, TDEST};
  assign TKEEP  = {TKEEP_WIDTH{streaming}};
  assign BUSY   = active || done_q;

endmodule

// File: tb/tb_axi4_stream_burst_scheduler.sv
// Scoreboard bench: a round-robin queue model predicts grant order, beats and
// handshake timing; a negedge monitor compares whatever the scheduler presents.
module tb_axi4_stream_burst_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int LEN_W    = 32;
  localparam int IDLE_GAP = 2;

  logic                     ACLK = 1'b0;
  logic                     RSTN;
  logic [NUM_REQ-1:0]       REQ;
  logic [NUM_REQ*LEN_W-1:0] REQ_LEN;
  logic [NUM_REQ-1:0]       ACK;
  logic [NUM_REQ-1:0]       DONE;
  logic                     TREADY;
  logic                     TVALID;
  logic                     TLAST;
  logic [1:0]               TDEST;
  logic [7:0]               TID;
  logic [3:0]               TKEEP;
  logic                     BUSY;
`ifdef AXI4_STREAM_BURST_SCHEDULER_ABORT_EN
  logic                     ABORT;
  logic                     ABORTED;
`endif

  axi4_stream_burst_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .LEN_W    (LEN_W),
    .IDLE_GAP (IDLE_GAP)
  ) dut (
    .ACLK    (ACLK),
    .RSTN    (RSTN),
    .REQ     (REQ),
    .REQ_LEN (REQ_LEN),
    .ACK     (ACK),
    .DONE    (DONE),
    .TREADY  (TREADY),
    .TVALID  (TVALID),
    .TLAST   (TLAST),
    .TDEST   (TDEST),
    .TID     (TID),
    .TKEEP   (TKEEP),
    .BUSY    (BUSY)
`ifdef AXI4_STREAM_BURST_SCHEDULER_ABORT_EN
    ,
    .ABORT   (ABORT),
    .ABORTED (ABORTED)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int idx;
    bit first;
  } ack_t;

  typedef struct {
    logic [1:0] dest;
    bit         last;
  } beat_t;

  ack_t  exp_acks[$];
  beat_t exp_beats[$];
  int    exp_dones[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int m_ptr = 0;
  int round_start_cyc = 0;
  int last_tlast_cyc = 0;
  int beat_cnt = 0;

  bit         prev_stall = 1'b0;
  logic       prev_tlast;
  logic [1:0] prev_tdest;
  beat_t      mon_beat;
  ack_t       mon_ack;
  int         mon_done;
  logic [3:0] mon_exp;

  int ml[4];
  int dl[4];
  bit ready_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: all listed requesters are pending together; serve the first
  // pending index at or after the pointer, pointer moves past the winner.
  // A requester in 're' rejoins the pending set once after its first burst.
  task automatic model_round(input logic [3:0] mask, input logic [3:0] re, input int lens[4]);
    logic [3:0] pend;
    bit first;
    int k;
    pend  = mask;
    first = 1'b1;
    while (pend != 4'b0) begin
      k = -1;
      for (int off = 0; off < NUM_REQ; off++)
        if (k < 0 && pend[(m_ptr + off) % NUM_REQ]) k = (m_ptr + off) % NUM_REQ;
      exp_acks.push_back('{idx: k, first: first});
      first = 1'b0;
      for (int n = 0; n <= lens[k]; n++)
        exp_beats.push_back('{dest: 2'(k), last: (n == lens[k])});
      exp_dones.push_back(k);
      m_ptr   = (k + 1) % NUM_REQ;
      pend[k] = 1'b0;
      if (re[k]) begin
        pend[k] = 1'b1;
        re[k]   = 1'b0;
      end
    end
  endtask

  // mode: 0 = TREADY always high, 1 = random, 2 = fixed stall pattern per presented beat.
  task automatic serve(input logic [3:0] mask, input logic [3:0] re, input int mlens[4],
                       input int dlens[4], input int mode);
    logic [3:0] re_left;
    int budget;
    int pi;
    re_left = re;
    model_round(mask, re, mlens);
    for (int i = 0; i < NUM_REQ; i++)
      if (mask[i]) REQ_LEN[i*LEN_W +: LEN_W] = dlens[i];
    @(posedge ACLK); #1;
    round_start_cyc = cyc;
    REQ    = mask;
    budget = 0;
    pi     = 0;
    while ((exp_acks.size() + exp_beats.size() + exp_dones.size()) != 0 && budget < 4000) begin
      case (mode)
        0:       TREADY = 1'b1;
        1:       TREADY = ($urandom_range(0, 3) != 0);
        default: begin
          TREADY = TVALID ? ((pi < 5) ? ready_pat[pi] : 1'b1) : 1'b0;
          if (TVALID) pi++;
        end
      endcase
      @(posedge ACLK); #1;
      budget++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ACK[i]) begin
          REQ[i] = 1'b0;
          REQ_LEN[i*LEN_W +: LEN_W] = $urandom;
        end
        if (DONE[i] && re_left[i]) begin
          REQ[i] = 1'b1;
          REQ_LEN[i*LEN_W +: LEN_W] = dlens[i];
          re_left[i] = 1'b0;
        end
      end
    end
    check("round_complete", budget < 4000, 1'b1);
    REQ    = '0;
    TREADY = 1'b0;
    repeat (IDLE_GAP + 3) @(posedge ACLK);
  endtask

  always @(negedge ACLK) begin
    if (!RSTN) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", TVALID, 1'b1);
        check("stall_tlast", TLAST, prev_tlast);
        check("stall_tdest", TDEST, prev_tdest);
      end
      if (TVALID && TREADY) begin
        beat_cnt++;
        if (exp_beats.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got beat to TDEST %0d, expected no beat", TDEST);
        end else begin
          mon_beat = exp_beats.pop_front();
          check("beat_tdest", TDEST, mon_beat.dest);
          check("beat_tid", TID, 8'(mon_beat.dest));
          check("beat_tlast", TLAST, mon_beat.last);
          check("beat_tkeep", TKEEP, 4'hF);
        end
        if (TLAST) last_tlast_cyc = cyc;
      end
      if (ACK != 4'b0) begin
        if (exp_acks.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: got ACK %b, expected none", ACK);
        end else begin
          mon_ack = exp_acks.pop_front();
          mon_exp = '0;
          mon_exp[mon_ack.idx] = 1'b1;
          check("ack_vector", ACK, mon_exp);
          check("ack_busy", BUSY, 1'b1);
          check("ack_cycle", cyc, mon_ack.first ? round_start_cyc + 1
                                                : last_tlast_cyc + IDLE_GAP + 2);
        end
      end
      if (DONE != 4'b0) begin
        if (exp_dones.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got DONE %b, expected none", DONE);
        end else begin
          mon_done = exp_dones.pop_front();
          mon_exp = '0;
          mon_exp[mon_done] = 1'b1;
          check("done_vector", DONE, mon_exp);
          check("done_cycle", cyc, last_tlast_cyc + 1);
        end
      end
      prev_stall = TVALID && !TREADY;
      prev_tlast = TLAST;
      prev_tdest = TDEST;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, TVALID, 1'b0);
    check({tag, "_tlast"}, TLAST, 1'b0);
    check({tag, "_tdest"}, TDEST, 2'b0);
    check({tag, "_tid"}, TID, 8'b0);
    check({tag, "_tkeep"}, TKEEP, 4'b0);
    check({tag, "_ack"}, ACK, 4'b0);
    check({tag, "_done"}, DONE, 4'b0);
    check({tag, "_busy"}, BUSY, 1'b0);
  endtask

  initial begin
    int budget;
    int b0;
    RSTN    = 1'b0;
    REQ     = '0;
    REQ_LEN = '0;
    TREADY  = 1'b0;
`ifdef AXI4_STREAM_BURST_SCHEDULER_ABORT_EN
    ABORT   = 1'b0;
`endif
    #3;
    check_all_zero("reset");
`ifdef AXI4_STREAM_BURST_SCHEDULER_ABORT_EN
    check("reset_aborted", ABORTED, 1'b0);
`endif
    repeat (3) @(posedge ACLK);
    #2 RSTN = 1'b1;
    repeat (2) @(posedge ACLK);

    // Single request, length 3 -> four beats to TDEST 0.
    ml = '{3, 0, 0, 0};
    serve(4'b0001, 4'b0000, ml, ml, 0);

    // Contention: req1 then req3, two beats each.
    ml = '{0, 1, 0, 1};
    serve(4'b1010, 4'b0000, ml, ml, 0);

    // Backpressure: three beats under a 1,0,0,1,1 ready pattern.
    ml = '{2, 0, 0, 0};
    serve(4'b0001, 4'b0000, ml, ml, 2);

    // Zero length: single beat carrying TLAST.
    ml = '{0, 0, 0, 0};
    serve(4'b0100, 4'b0000, ml, ml, 0);

    // Leave the pointer at 2 so the post-reset pick exposes a pointer that failed to clear.
    serve(4'b0010, 4'b0000, ml, ml, 1);

    // Reset during beat 2 of a 5-beat burst.
    ml = '{0, 4, 0, 0};
    model_round(4'b0010, 4'b0000, ml);
    REQ_LEN[1*LEN_W +: LEN_W] = 4;
    TREADY = 1'b1;
    @(posedge ACLK); #1;
    round_start_cyc = cyc;
    REQ    = 4'b0010;
    b0     = beat_cnt;
    budget = 0;
    while (beat_cnt < b0 + 1 && budget < 100) begin
      @(posedge ACLK); #1;
      budget++;
      if (ACK[1]) REQ[1] = 1'b0;
    end
    check("reset_test_reached_beat2", budget < 100, 1'b1);
    check("reset_test_tvalid_before", TVALID, 1'b1);
    RSTN = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    exp_acks.delete();
    exp_beats.delete();
    exp_dones.delete();
    m_ptr  = 0;
    REQ    = '0;
    TREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #2 RSTN = 1'b1;
    repeat (2) @(posedge ACLK);
    ml = '{0, 2, 0, 1};
    serve(4'b1010, 4'b0000, ml, ml, 1);

    // Fairness: req0 re-requests in its DONE cycle and must wait behind req1.
    ml = '{1, 2, 0, 0};
    serve(4'b0011, 4'b0001, ml, ml, 1);

    // Randomized rounds with random backpressure and post-ACK length scrambling.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NUM_REQ; i++)
        ml[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 30))
                                            : int'($urandom_range(0, 5));
      serve(4'($urandom_range(1, 15)), 4'b0000, ml, ml, 1);
    end

`ifdef AXI4_STREAM_BURST_SCHEDULER_ABORT_EN
    // Length 9 cut short: ABORT seen with beat 1 makes beat 2 the last.
    ml = '{1, 0, 0, 0};
    dl = '{9, 0, 0, 0};
    ABORT = 1'b1;
    serve(4'b0001, 4'b0000, ml, dl, 0);
    ABORT = 1'b0;
    check("aborted_sticky", ABORTED, 1'b1);
    ml = '{1, 0, 0, 0};
    serve(4'b0001, 4'b0000, ml, ml, 0);
    check("aborted_cleared", ABORTED, 1'b0);
`endif

    check("leftover_expectations", exp_acks.size() + exp_beats.size() + exp_dones.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
